// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential radix-2 multiplier.
package seq_mult_pkg;

    localparam int SEQ_MULT_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_cond_neg.sv
// Conditional two's-complement negator: result = neg ? -data : data.
module seq_mult_cond_neg #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~data + W'(1)) : data;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Define SEQ_MULT_SIGNED_EN to honour signed_mode (sign-magnitude around an unsigned core).
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | WIDTH shift-add iterations
// DONE  | product valid, held until out_ready
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     product_q, product_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              neg_in;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     prod_final;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_a, sign_b;

    assign sign_a = signed_mode & a[WIDTH-1];
    assign sign_b = signed_mode & b[WIDTH-1];
    assign neg_in = sign_a ^ sign_b;

    // Magnitude of the most-negative operand is 2^(WIDTH-1), which still fits unsigned.
    seq_mult_cond_neg #(.W(WIDTH)) u_neg_a (.data(a), .neg(sign_a), .result(mag_a));
    seq_mult_cond_neg #(.W(WIDTH)) u_neg_b (.data(b), .neg(sign_b), .result(mag_b));
    seq_mult_cond_neg #(.W(PW))    u_neg_p (.data(acc_sum), .neg(neg_q), .result(prod_final));
`else
    logic unused_sign;

    assign unused_sign = signed_mode ^ neg_q;
    assign neg_in      = 1'b0;
    assign mag_a       = a;
    assign mag_b       = b;
    assign prod_final  = acc_sum;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    acc_d      = '0;
                    mcand_d    = {{WIDTH{1'b0}}, mag_a};
                    mplier_d   = mag_b;
                    neg_d      = neg_in;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    product_d   = prod_final;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Ready is masked while reset is held so nothing upstream sees a false accept.
    assign in_ready  = in_ready_q & rst_n;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed WIDTH=4 scenarios plus a randomized WIDTH=16 run.
module tb_seq_mult;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        in_valid4 = 1'b0, in_ready4, sm4 = 1'b0, out_valid4, out_ready4 = 1'b0, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    logic        in_valid16 = 1'b0, in_ready16, sm16 = 1'b0, out_valid16, out_ready16 = 1'b0, busy16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] product16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(out_ready4), .product(product4), .busy(busy4)
    );

    seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .signed_mode(sm16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16), .busy(busy16)
    );

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input logic sm);
        longint sx, sy, p;
        sx = longint'(x);
        sy = longint'(y);
        if (sm && SIGNED_EN) begin
            if (x[w-1]) sx = sx - (longint'(1) << w);
            if (y[w-1]) sy = sy - (longint'(1) << w);
        end
        p = sx * sy;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept4(input logic [3:0] x, input logic [3:0] y, input logic sm);
        in_valid4 = 1'b1;
        a4 = x;
        b4 = y;
        sm4 = sm;
        step();
        in_valid4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        sm4 = 1'($urandom);
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (!out_valid4 && n < 40) begin
            step();
            n++;
        end
        if (!out_valid4) n = -1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || product4 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got rdy=%b ov=%b busy=%b prod=%h want 0 0 0 00",
                     in_ready4, out_valid4, busy4, product4);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready4 !== 1'b1 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b/%b want 1/1", in_ready4, in_ready16);
        end
    endtask

    task automatic test_unsigned();
        int n;
        out_ready4 = 1'b1;
        accept4(4'd15, 4'd15, 1'b0);
        checks++;
        if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_busy got busy=%b rdy=%b want 1 0", busy4, in_ready4);
        end
        wait_valid4(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL unsigned_latency got %0d want 4", n);
        end
        checks++;
        if (product4 !== 8'd225) begin
            errors++;
            $display("FAIL unsigned_15x15 got %0d want 225", product4);
        end
        step();
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_release got ov=%b rdy=%b busy=%b want 0 1 0",
                     out_valid4, in_ready4, busy4);
        end
    endtask

    task automatic test_signed();
        logic [3:0] xs [4] = '{4'h8, 4'h8, 4'hD, 4'hD};
        logic [3:0] ys [4] = '{4'h8, 4'h7, 4'h5, 4'h5};
        logic       ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] e;
        int n;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept4(xs[i], ys[i], ss[i]);
            wait_valid4(n);
            e = ref_prod(4, {28'b0, xs[i]}, {28'b0, ys[i]}, ss[i]);
            if (i == 0) e = 64'h40;
            if (i == 1) e = SIGNED_EN ? 64'hC8 : 64'h38;
            checks++;
            if (n != 4 || product4 !== e[7:0]) begin
                errors++;
                $display("FAIL signed_case%0d got prod=%h lat=%0d want prod=%h lat=4",
                         i, product4, n, e[7:0]);
            end
            step();
        end
    endtask

    task automatic test_zero();
        int busy_cnt = 0;
        int lat = -1;
        out_ready4 = 1'b1;
        accept4(4'd0, 4'd9, 1'b0);
        while (busy4 === 1'b1 && busy_cnt < 30) begin
            if (out_valid4 === 1'b1 && lat < 0) begin
                lat = busy_cnt;
                checks++;
                if (product4 !== 8'h00) begin
                    errors++;
                    $display("FAIL zero_product got %h want 00", product4);
                end
            end
            busy_cnt++;
            step();
        end
        checks++;
        if (busy_cnt != 5 || lat != 4) begin
            errors++;
            $display("FAIL zero_timing got busy=%0d lat=%0d want busy=5 lat=4", busy_cnt, lat);
        end
    endtask

    task automatic test_hold();
        int n;
        out_ready4 = 1'b0;
        accept4(4'd13, 4'd11, 1'b0);
        wait_valid4(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL hold_latency got %0d want 4", n);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid4 = 1'b1;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            step();
            checks++;
            if (out_valid4 !== 1'b1 || product4 !== 8'd143 || in_ready4 !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got ov=%b prod=%0d rdy=%b want 1 143 0",
                         i, out_valid4, product4, in_ready4);
            end
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        step();
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || product4 !== 8'd143) begin
            errors++;
            $display("FAIL hold_release got ov=%b rdy=%b prod=%0d want 0 1 143",
                     out_valid4, in_ready4, product4);
        end
    endtask

    task automatic test_abort();
        int n;
        int seen = 0;
        out_ready4 = 1'b1;
        accept4(4'd5, 4'd6, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid4 !== 1'b0 || product4 !== 8'h00 || busy4 !== 1'b0 || in_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got ov=%b prod=%h busy=%b rdy=%b want 0 00 0 0",
                     out_valid4, product4, busy4, in_ready4);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got rdy=%b want 1", in_ready4);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid4 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d valid cycles want 0", seen);
        end
        accept4(4'd9, 4'd7, 1'b0);
        wait_valid4(n);
        checks++;
        if (n != 4 || product4 !== 8'd63) begin
            errors++;
            $display("FAIL abort_next got prod=%0d lat=%0d want 63 lat=4", product4, n);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        int rise [$];
        logic [63:0] e;
        logic [3:0] x, y;
        int sent = 0;
        int cyc = 0;
        out_ready4 = 1'b1;
        while (rise.size() < 4 && cyc < 80) begin
            if (out_valid4 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got prod=%h want no result", product4);
                end else begin
                    if (product4 !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_product got %h want %h", product4, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                rise.push_back(cyc);
            end
            x = 4'($urandom);
            y = 4'($urandom);
            in_valid4 = (sent < 4);
            a4 = x;
            b4 = y;
            sm4 = 1'b0;
            if (in_ready4 === 1'b1 && in_valid4) begin
                e = ref_prod(4, {28'b0, x}, {28'b0, y}, 1'b0);
                exp_q.push_back(e[7:0]);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid4 = 1'b0;
        checks++;
        if (rise.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", rise.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rise[i] - rise[i-1] != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d want 6", rise[i] - rise[i-1]);
                end
            end
        end
    endtask

    task automatic test_random16();
        logic [31:0] exp_q [$];
        logic [63:0] e;
        logic [15:0] x, y;
        logic sm;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            if (out_valid16 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand16_spurious got prod=%h want no result", product16);
                end else if (product16 !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand16_product got %h want %h", product16, exp_q[0]);
                end
            end
            out_ready16 = 1'($urandom_range(0, 1));
            if (out_valid16 === 1'b1 && out_ready16 && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            x = pick16();
            y = pick16();
            sm = 1'($urandom_range(0, 1));
            in_valid16 = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a16 = x;
            b16 = y;
            sm16 = sm;
            if (in_ready16 === 1'b1 && in_valid16) begin
                e = ref_prod(16, {16'b0, x}, {16'b0, y}, sm);
                exp_q.push_back(e[31:0]);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid16 = 1'b0;
        checks++;
        if (got != 1000) begin
            errors++;
            $display("FAIL rand16_completed got %0d want 1000", got);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
